// File: rtl/pwm_fade.sv
// pwm_fade: prescaler and fade sequencer that drive a PWM generator.
// The prescaler emits the counter-advance strobe. The fade FSM steps the compare
// value once per PWM period: ramp up, hold high, ramp down, hold low, repeat.
// Optional build macro PWM_FADE_CYCLE_CNT_EN adds cycle_cnt_o, which counts
// completed fade cycles (HOLD_LOW->RAMP_UP transitions).
module pwm_fade #(
   parameter int COUNTER_WIDTH = 10,
   parameter int PRESC_WIDTH   = 8,
   parameter int STEP_WIDTH    = 6,
   parameter int HOLD_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable_i,
   input  logic [PRESC_WIDTH-1:0]   prescale_i,
   input  logic [COUNTER_WIDTH-1:0] min_duty_i,
   input  logic [COUNTER_WIDTH-1:0] max_duty_i,
   input  logic [STEP_WIDTH-1:0]    step_i,
   input  logic [HOLD_WIDTH-1:0]    hold_periods_i,
   input  logic                     period_start_i,
   output logic                     pwm_set_o,
   output logic [COUNTER_WIDTH-1:0] cmp_value_o,
   output logic [2:0]               state_o
`ifdef PWM_FADE_CYCLE_CNT_EN
   ,
   output logic [7:0]               cycle_cnt_o
`endif
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RAMP_UP   = 3'd1;
   localparam logic [2:0] ST_HOLD_HIGH = 3'd2;
   localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
   localparam logic [2:0] ST_HOLD_LOW  = 3'd4;

   logic [PRESC_WIDTH-1:0]   r_presc_cnt;
   logic                     r_pwm_set;
   logic [2:0]               r_state;
   logic [COUNTER_WIDTH-1:0] r_cmp;
   logic [HOLD_WIDTH-1:0]    r_hold_cnt;

   logic [2:0]               w_state_next;
   logic [COUNTER_WIDTH-1:0] w_cmp_next;
   logic [HOLD_WIDTH-1:0]    w_hold_next;
   logic [COUNTER_WIDTH:0]   w_step_ext;
   logic [COUNTER_WIDTH:0]   w_sum;
   logic [COUNTER_WIDTH:0]   w_diff;
   logic [COUNTER_WIDTH-1:0] w_up_val;
   logic [COUNTER_WIDTH-1:0] w_dn_val;
   logic                     w_degen;

`ifdef PWM_FADE_CYCLE_CNT_EN
   logic [7:0]               r_cycle_cnt;
   logic [7:0]               w_cycle_next;
`endif

   // Prescaler: strobe when the count matches prescale_i, held idle while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc_cnt <= '0;
         r_pwm_set   <= 1'b0;
      end else if (!enable_i) begin
         r_presc_cnt <= '0;
         r_pwm_set   <= 1'b0;
      end else if (r_presc_cnt == prescale_i) begin
         r_presc_cnt <= '0;
         r_pwm_set   <= 1'b1;
      end else begin
         r_presc_cnt <= r_presc_cnt + PRESC_WIDTH'(1);
         r_pwm_set   <= 1'b0;
      end
   end

   // Clamped ramp arithmetic: one extra bit catches overflow on the way up and borrow on the way down.
   always_comb begin
      w_step_ext = {{(COUNTER_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_i};
      if (step_i == '0) begin
         w_step_ext = (COUNTER_WIDTH + 1)'(1);
      end else begin
         w_step_ext = {{(COUNTER_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_i};
      end
      w_sum   = {1'b0, r_cmp} + w_step_ext;
      w_diff  = {1'b0, r_cmp} - w_step_ext;
      w_degen = (min_duty_i >= max_duty_i);

      if (w_sum >= {1'b0, max_duty_i}) begin
         w_up_val = max_duty_i;
      end else if (w_sum[COUNTER_WIDTH-1:0] < min_duty_i) begin
         w_up_val = min_duty_i;
      end else begin
         w_up_val = w_sum[COUNTER_WIDTH-1:0];
      end

      if (w_diff[COUNTER_WIDTH] || (w_diff[COUNTER_WIDTH-1:0] <= min_duty_i)) begin
         w_dn_val = min_duty_i;
      end else if (w_diff[COUNTER_WIDTH-1:0] > max_duty_i) begin
         w_dn_val = max_duty_i;
      end else begin
         w_dn_val = w_diff[COUNTER_WIDTH-1:0];
      end
   end

   // Fade FSM next-state and datapath: disable wins; otherwise advance only on period_start_i.
   always_comb begin
      w_state_next = r_state;
      w_cmp_next   = r_cmp;
      w_hold_next  = r_hold_cnt;
`ifdef PWM_FADE_CYCLE_CNT_EN
      w_cycle_next = r_cycle_cnt;
`endif
      if (!enable_i) begin
         w_state_next = ST_IDLE;
         w_cmp_next   = min_duty_i;
         w_hold_next  = '0;
`ifdef PWM_FADE_CYCLE_CNT_EN
         w_cycle_next = 8'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_next = ST_RAMP_UP;
               w_cmp_next   = min_duty_i;
               w_hold_next  = '0;
            end
            ST_RAMP_UP, ST_HOLD_HIGH, ST_RAMP_DOWN, ST_HOLD_LOW: begin
               if (!period_start_i) begin
                  w_state_next = r_state;
               end else if (w_degen) begin
                  // Unusable bounds: park at the low bound until they become valid.
                  w_state_next = ST_HOLD_LOW;
                  w_cmp_next   = min_duty_i;
                  w_hold_next  = '0;
               end else begin
                  case (r_state)
                     ST_RAMP_UP: begin
                        w_cmp_next = w_up_val;
                        if (w_up_val == max_duty_i) begin
                           w_state_next = ST_HOLD_HIGH;
                           w_hold_next  = '0;
                        end else begin
                           w_state_next = ST_RAMP_UP;
                        end
                     end
                     ST_HOLD_HIGH: begin
                        if (r_hold_cnt == hold_periods_i) begin
                           w_state_next = ST_RAMP_DOWN;
                        end else begin
                           w_hold_next = r_hold_cnt + HOLD_WIDTH'(1);
                        end
                     end
                     ST_RAMP_DOWN: begin
                        w_cmp_next = w_dn_val;
                        if (w_dn_val == min_duty_i) begin
                           w_state_next = ST_HOLD_LOW;
                           w_hold_next  = '0;
                        end else begin
                           w_state_next = ST_RAMP_DOWN;
                        end
                     end
                     default: begin
                        if (r_hold_cnt == hold_periods_i) begin
                           w_state_next = ST_RAMP_UP;
`ifdef PWM_FADE_CYCLE_CNT_EN
                           w_cycle_next = r_cycle_cnt + 8'd1;
`endif
                        end else begin
                           w_hold_next = r_hold_cnt + HOLD_WIDTH'(1);
                        end
                     end
                  endcase
               end
            end
            default: begin
               // Unreachable encodings recover through IDLE.
               w_state_next = ST_IDLE;
               w_cmp_next   = min_duty_i;
               w_hold_next  = '0;
            end
         endcase
      end
   end

   // Fade FSM state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cmp      <= '0;
         r_hold_cnt <= '0;
`ifdef PWM_FADE_CYCLE_CNT_EN
         r_cycle_cnt <= 8'd0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_cmp      <= w_cmp_next;
         r_hold_cnt <= w_hold_next;
`ifdef PWM_FADE_CYCLE_CNT_EN
         r_cycle_cnt <= w_cycle_next;
`endif
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      pwm_set_o   = r_pwm_set;
      cmp_value_o = r_cmp;
      state_o     = r_state;
`ifdef PWM_FADE_CYCLE_CNT_EN
      cycle_cnt_o = r_cycle_cnt;
`endif
   end

endmodule
